// File: rtl/imem_responder_if.sv
// Fetch-side bus between the program counter / decode and the instruction memory.
// Carries the request, response and boot-load channels.
interface imem_responder_if;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        fetch_advance;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_instr;
    logic [31:0] resp_addr;
    logic        resp_error;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;

    modport master (
        output req_valid, req_addr, flush, resp_ready,
        output load_en, load_addr, load_data,
        input  req_ready, fetch_advance,
        input  resp_valid, resp_instr, resp_addr, resp_error
    );

    modport slave (
        input  req_valid, req_addr, flush, resp_ready,
        input  load_en, load_addr, load_data,
        output req_ready, fetch_advance,
        output resp_valid, resp_instr, resp_addr, resp_error
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction memory responder: accepts PC fetches, waits LATENCY states,
// returns the word towards decode; supports flush and a word load port.
module imem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0040_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter string       INIT_FILE   = ""
) (
    input logic             clock,
    input logic             reset_n,
    imem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  count;
    logic [31:0] addr_q;
    logic        valid_q;
    logic        error_q;
    logic [31:0] instr_q;
    logic [31:0] raddr_q;
    logic [31:0] mem [DEPTH_WORDS];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a - BASE_ADDR) >> 2;
    endfunction

    function automatic logic bad_addr(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a < BASE_ADDR)
            || (word_of(a) >= 32'(DEPTH_WORDS));
    endfunction

    logic          accept;
    logic [31:0]   cap_addr;
    logic          cap_bad;
    logic [AW-1:0] cap_idx;
    logic          load_bad;
    logic [AW-1:0] load_idx;

    assign bus.req_ready = (state == IDLE)
                        || (state == RESP && bus.resp_ready)
                        || bus.flush;
    assign accept            = bus.req_valid && bus.req_ready;
    assign bus.fetch_advance = accept;

    assign cap_addr = (LATENCY == 0) ? bus.req_addr : addr_q;
    assign cap_bad  = bad_addr(cap_addr);
    assign cap_idx  = AW'(word_of(cap_addr));
    assign load_bad = bad_addr(bus.load_addr);
    assign load_idx = AW'(word_of(bus.load_addr));

    assign bus.resp_valid = valid_q;
    assign bus.resp_instr = instr_q;
    assign bus.resp_addr  = raddr_q;
    assign bus.resp_error = error_q;

    always_ff @(posedge clock) begin
        if (reset_n && bus.load_en && !load_bad)
            mem[load_idx] <= bus.load_data;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state   <= IDLE;
            count   <= 4'd0;
            addr_q  <= 32'd0;
            valid_q <= 1'b0;
            instr_q <= 32'd0;
            raddr_q <= 32'd0;
            error_q <= 1'b0;
        end else if (accept) begin
            addr_q <= bus.req_addr;
            if (LATENCY == 0) begin
                state   <= RESP;
                valid_q <= 1'b1;
                instr_q <= cap_bad ? 32'd0 : mem[cap_idx];
                raddr_q <= cap_addr;
                error_q <= cap_bad;
            end else begin
                state   <= WAIT;
                count   <= 4'(LATENCY);
                valid_q <= 1'b0;
            end
        end else if (bus.flush) begin
            state   <= IDLE;
            count   <= 4'd0;
            valid_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: ;
                WAIT: begin
                    if (count == 4'd1) begin
                        state   <= RESP;
                        count   <= 4'd0;
                        valid_q <= 1'b1;
                        instr_q <= cap_bad ? 32'd0 : mem[cap_idx];
                        raddr_q <= cap_addr;
                        error_q <= cap_bad;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule
